heat_column_walker: RTL and testbench
=====================================

# heat_column_walker

Per-column sequencer for the heat-map solver: owns one grid column in a 256×32 M10K and walks it top to bottom once per time step. It presents a sliding three-row window (up, center, down) plus lockstep left/right neighbour values to the node-update datapath, and writes that datapath's new center back in place. One instance sits per grid column. Neighbouring instances exchange `center_out`, and the VGA side reads the column between steps.

## Interface
- `NUM_ROWS`, 256, rows in the column (3..256)
- `ADDR_W`, 8, row address width
- `clk`  in  1  system clock
- `reset_n`  in  1  synchronous, active-low reset
- `init_we`  in  1  load-port write strobe; honoured only in IDLE
- `init_addr`  in  ADDR_W  load row
- `init_data`  in  32  load value, signed 5.27
- `start`  in  1  single-cycle pulse; begin one time step
- `left_in`, `right_in`  in  32  neighbour columns' `center_out`, same row, same cycle
- `new_center`  in  32  updated value returned combinationally by the update datapath
- `center_out`  out  32  this column's current center register, for neighbours
- `node_center`, `node_up`, `node_down`, `node_left`, `node_right`  out  32  window to the update datapath
- `calc_valid`  out  1  window valid; `new_center` is written this cycle
- `calc_row`  out  ADDR_W  row being updated
- `busy`  out  1  step in progress
- `done`  out  1  one-cycle pulse after the last write
- `disp_addr`  in  ADDR_W  display read row, IDLE only
- `disp_data`  out  32  display data, one-cycle read latency

## Operation
- States:
  - IDLE: `busy`=0. Accepts `init_we` and `disp_addr`. `start` moves to READ.
  - READ: issues row reads 0..NUM_ROWS-1, one per cycle. After the last read it moves to FLUSH.
  - FLUSH: completes the final update.
  - FIN: pulses `done` and returns to IDLE.
- Window registers `up_r` and `ctr_r`; `down` is the memory output. Each cycle that read data returns: `up_r`←`ctr_r`, `ctr_r`←`q`.
- Outputs are driven directly from the window: `node_up`=`up_r`, `node_center`=`ctr_r`=`center_out`, `node_down`=`q`, `node_left`=`left_in`, `node_right`=`right_in`.
- Updates cover only rows 1..NUM_ROWS-2. Rows 0 and NUM_ROWS-1 are fixed boundary rows: never written and never asserting `calc_valid`.
- In-place write-back is safe:
  - The old value of row r-1 is already captured in `up_r` before row r-1 is overwritten.
  - Left/right columns supply old values because all columns run in lockstep from a common `start`.
- Data are signed 5.27 and pass through unmodified. No saturation or arithmetic occurs in this block.
- `start` while `busy`=1 is ignored. `init_we` while `busy`=1 is dropped.
- `init_we` and `start` in the same IDLE cycle: the write is performed and the step starts. The write lands before the row-0 read.
- During a step, `disp_data` holds its last value and `disp_addr` is ignored.
- Reset mid-step returns to IDLE. Column contents are then partially updated and defined only per row written so far; the bench reloads before checking.
- Reset values: `busy`=0, `done`=0, `calc_valid`=0, `calc_row`=0, `up_r`=`ctr_r`=0 (so `center_out`=0).
- `disp_data` and `node_down` (memory output) are not reset. They are valid one cycle after the first read.

## Timing
- Start sampled at cycle s. Row r read address is presented at s+1+r; its data are available at s+2+r.
- Update of row r (1..NUM_ROWS-2): `calc_valid`=1 and `calc_row`=r at cycle s+3+r. The memory write occurs at that cycle's edge.
- `busy`=1 from s+1 through s+NUM_ROWS+2. `done`=1 at s+NUM_ROWS+2 only.
- Throughput: one row per cycle, NUM_ROWS+2 cycles per step.
- Display read: `disp_addr` at cycle t gives `disp_data` at t+1.

## Structure
- Shared package: `FP_ONE`=32'h0800_0000, `FP_SRC`=+8.0, `FP_SNK`=-8.0 (5.27), `ROW_ADDR_W`, and the state encoding.
- One sub-module, `column_ram`: simple dual-port 256×32 M10K with a registered read and no read-during-write check. The write port is muxed between the init port and the update path; the read port is muxed between the sequencer and `disp_addr`.
- The update datapath is external; it is wired at the top level next to this block.

## Test plan
- Load all rows 0, row 5 = 0x0800_0000, `alpha_delta` = 0x0200_0000, one step. Required after the step:
  - Rows 4 and 6 = 0x0200_0000.
  - Row 5 = 0x0000_0000.
  - `done` at s+258.
- Load ramp row r = r<<20, step. Then:
  - Rows 0 and 255 are unchanged.
  - `calc_row` sequence is 1..254 on consecutive cycles.
  - `calc_valid` never fires for rows 0 and 255.
- Three lockstep instances, middle column row 10 = 0x0800_0000, others 0. After one step, the outer columns' row 10 = 0x0200_0000.
- `start` re-pulsed at s+50: ignored, `done` still single at s+258. `init_we` at s+60 is dropped and the memory is unchanged.
- Reset at s+100: the next cycle shows `busy`=0 and `calc_valid`=0. After reload and restart, the result matches the first scenario.
- IDLE display read of row 5 after the first scenario: `disp_data` = 0x0000_0000 one cycle after `disp_addr`=5.

Source files
------------

// File: rtl/heat_column_walker_pkg.sv
// Shared constants and types for the heat-map column sequencer.
package heat_column_walker_pkg;

  localparam int ROW_ADDR_W = 8;
  localparam int DATA_W     = 32;

  // Signed 5.27 fixed-point constants used by the solver.
  localparam logic [DATA_W-1:0] FP_ONE = 32'h0800_0000;
  localparam logic [DATA_W-1:0] FP_SRC = 32'h4000_0000;  // +8.0
  localparam logic [DATA_W-1:0] FP_SNK = 32'hC000_0000;  // -8.0

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FIN   = 2'd3
  } walk_state_e;

  // Boundary rows (first and last) hold fixed values and are never rewritten.
  function automatic logic is_interior_row(input int row, input int num_rows);
    return (row > 0) && (row < num_rows - 1);
  endfunction

endpackage

// File: rtl/heat_column_walker_if.sv
// Bundle between a column walker, its update datapath, neighbours, loader and display.
interface heat_column_walker_if #(
  parameter int ADDR_W = heat_column_walker_pkg::ROW_ADDR_W
);
  import heat_column_walker_pkg::*;

  logic                init_we;
  logic [ADDR_W-1:0]   init_addr;
  logic [DATA_W-1:0]   init_data;
  logic                start;
  logic [DATA_W-1:0]   left_in;
  logic [DATA_W-1:0]   right_in;
  logic [DATA_W-1:0]   new_center;
  logic [DATA_W-1:0]   center_out;
  logic [DATA_W-1:0]   node_center;
  logic [DATA_W-1:0]   node_up;
  logic [DATA_W-1:0]   node_down;
  logic [DATA_W-1:0]   node_left;
  logic [DATA_W-1:0]   node_right;
  logic                calc_valid;
  logic [ADDR_W-1:0]   calc_row;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   disp_addr;
  logic [DATA_W-1:0]   disp_data;

  modport slave (
    input  init_we, init_addr, init_data, start, left_in, right_in, new_center, disp_addr,
    output center_out, node_center, node_up, node_down, node_left, node_right,
           calc_valid, calc_row, busy, done, disp_data
  );

  modport master (
    output init_we, init_addr, init_data, start, left_in, right_in, new_center, disp_addr,
    input  center_out, node_center, node_up, node_down, node_left, node_right,
           calc_valid, calc_row, busy, done, disp_data
  );

endinterface

// File: rtl/heat_column_walker_column_ram.sv
// Simple dual-port column store with registered read; read-during-write returns old data.
module column_ram
  import heat_column_walker_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = ROW_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // One write and one registered read per cycle.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/heat_column_walker.sv
// Walks one grid column top to bottom per time step, presenting a three-row
// window to the external update datapath and writing its result back in place.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | loader and display own the RAM; start begins a step
//   ST_READ  | one row read per cycle, rows 0..NUM_ROWS-1
//   ST_FLUSH | last window in flight, final interior row written
//   ST_FIN   | done pulse, back to idle
module heat_column_walker
  import heat_column_walker_pkg::*;
#(
  parameter int NUM_ROWS = 256,
  parameter int ADDR_W   = ROW_ADDR_W
) (
  input logic                 clk,
  input logic                 reset_n,
  heat_column_walker_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

  walk_state_e       state_q;
  logic [ADDR_W-1:0] rd_row_q;
  logic [ADDR_W-1:0] q_row_q;
  logic [ADDR_W-1:0] calc_row_q;
  logic              q_vld_q;
  logic              calc_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              disp_sel_q;
  logic [DATA_W-1:0] up_q;
  logic [DATA_W-1:0] ctr_q;
  logic [DATA_W-1:0] disp_hold_q;

  logic              idle;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  assign idle = (state_q == ST_IDLE);

  // RAM ports belong to the loader/display while idle, to the sequencer otherwise.
  always_comb begin
    ram_we    = calc_valid_q;
    ram_waddr = calc_row_q;
    ram_wdata = bus.new_center;
    ram_raddr = rd_row_q;
    if (idle) begin
      ram_we    = bus.init_we;
      ram_waddr = bus.init_addr;
      ram_wdata = bus.init_data;
      ram_raddr = bus.disp_addr;
    end
  end

  column_ram #(
    .DEPTH  (NUM_ROWS),
    .ADDR_W (ADDR_W)
  ) u_column_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Step sequencer: row address walk plus registered busy/done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rd_row_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q  <= ST_READ;
            rd_row_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        ST_READ: begin
          if (rd_row_q == LAST_ROW) state_q <= ST_FLUSH;
          else                      rd_row_q <= rd_row_q + ADDR_W'(1);
        end
        ST_FLUSH: begin
          state_q <= ST_FIN;
          done_q  <= 1'b1;
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sliding window: shift when read data returns; the write of row r is
  // issued only after row r-1's old value already sits in up_q.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_vld_q      <= 1'b0;
      q_row_q      <= '0;
      up_q         <= '0;
      ctr_q        <= '0;
      calc_valid_q <= 1'b0;
      calc_row_q   <= '0;
      disp_sel_q   <= 1'b0;
    end else begin
      q_vld_q      <= (state_q == ST_READ);
      q_row_q      <= rd_row_q;
      calc_valid_q <= q_vld_q && is_interior_row(int'(q_row_q), NUM_ROWS);
      disp_sel_q   <= idle;
      if (q_vld_q) begin
        up_q       <= ctr_q;
        ctr_q      <= ram_rdata;
        calc_row_q <= q_row_q;
      end
    end
  end

  // Display data freezes at its last idle read while a step owns the RAM.
  always_ff @(posedge clk) begin
    if (disp_sel_q) disp_hold_q <= ram_rdata;
  end

  assign bus.center_out  = ctr_q;
  assign bus.node_center = ctr_q;
  assign bus.node_up     = up_q;
  assign bus.node_down   = ram_rdata;
  assign bus.node_left   = bus.left_in;
  assign bus.node_right  = bus.right_in;
  assign bus.calc_valid  = calc_valid_q;
  assign bus.calc_row    = calc_row_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.disp_data   = disp_sel_q ? ram_rdata : disp_hold_q;

endmodule

// File: tb/tb_heat_column_walker.sv
// Three lockstep column walkers with a behavioural heat-step model.
`timescale 1ns/1ps
module tb_heat_column_walker;
  import heat_column_walker_pkg::*;

  localparam int NR = 256;
  localparam int NC = 3;
  localparam logic [31:0] ALPHA_Q = 32'h0200_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        we_v [NC];
  logic [7:0]  wa_v [NC];
  logic [31:0] wd_v [NC];
  logic        start_v;
  logic [7:0]  disp_a;
  logic [31:0] ext_l, ext_r, alpha;

  logic [31:0] ctr_o [NC], nc_o [NC], up_o [NC], dn_o [NC], nl_o [NC], nr_o [NC], dd_o [NC];
  logic        cv_o [NC], busy_o [NC], done_o [NC];
  logic [7:0]  crow_o [NC];

  function automatic logic [31:0] heat_fn(input logic [31:0] u, input logic [31:0] d,
                                          input logic [31:0] l, input logic [31:0] r,
                                          input logic [31:0] c, input logic [31:0] a);
    longint sum, prod;
    sum  = longint'($signed(u)) + longint'($signed(d)) + longint'($signed(l))
         + longint'($signed(r)) - 4 * longint'($signed(c));
    prod = sum * longint'($signed(a));
    return 32'(longint'($signed(c)) + (prod >>> 27));
  endfunction

  for (genvar g = 0; g < NC; g++) begin : col
    heat_column_walker_if #(.ADDR_W(8)) hif ();
    heat_column_walker #(.NUM_ROWS(NR), .ADDR_W(8)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (hif)
    );
    assign hif.init_we   = we_v[g];
    assign hif.init_addr = wa_v[g];
    assign hif.init_data = wd_v[g];
    assign hif.start     = start_v;
    assign hif.disp_addr = disp_a;
    if (g == 0) begin : l_edge
      assign hif.left_in = ext_l;
    end else begin : l_nb
      assign hif.left_in = ctr_o[g-1];
    end
    if (g == NC - 1) begin : r_edge
      assign hif.right_in = ext_r;
    end else begin : r_nb
      assign hif.right_in = ctr_o[g+1];
    end
    assign hif.new_center = heat_fn(hif.node_up, hif.node_down, hif.node_left,
                                    hif.node_right, hif.node_center, alpha);
    assign ctr_o[g]  = hif.center_out;
    assign nc_o[g]   = hif.node_center;
    assign up_o[g]   = hif.node_up;
    assign dn_o[g]   = hif.node_down;
    assign nl_o[g]   = hif.node_left;
    assign nr_o[g]   = hif.node_right;
    assign dd_o[g]   = hif.disp_data;
    assign cv_o[g]   = hif.calc_valid;
    assign crow_o[g] = hif.calc_row;
    assign busy_o[g] = hif.busy;
    assign done_o[g] = hif.done;
  end

  // Model state: current column contents, snapshot at step start, expected result.
  logic [31:0] cur   [NC][NR];
  logic [31:0] old_g [NC][NR];
  logic [31:0] exp_g [NC][NR];
  logic [31:0] hold_exp [NC];

  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  bit  step_on = 1'b0;
  int  s_cyc = 0;
  int  cv_cnt, cv_first, cv_last, done_cnt, done_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [31:0] rand_fp();
    return 32'($urandom_range(0, 32'h1000_0000)) - 32'h0800_0000;
  endfunction

  // Jacobi step over interior rows; edge columns see the external boundary values.
  task automatic model_step();
    logic [31:0] l, r;
    old_g = cur;
    exp_g = cur;
    for (int c = 0; c < NC; c++)
      for (int i = 1; i < NR - 1; i++) begin
        l = (c == 0)      ? ext_l : cur[c-1][i];
        r = (c == NC - 1) ? ext_r : cur[c+1][i];
        exp_g[c][i] = heat_fn(cur[c][i-1], cur[c][i+1], l, r, cur[c][i], alpha);
      end
  endtask

  // Per-cycle comparison against the timing rules of a step.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < NC; c++) begin
        int rel, r;
        bit eb, ed, ev;
        logic [31:0] lexp, rexp;
        rel = cyc - s_cyc;
        r   = rel - 3;
        eb  = step_on && rel >= 1 && rel <= NR + 2;
        ed  = step_on && rel == NR + 2;
        ev  = step_on && r >= 1 && r <= NR - 2;
        chk("busy", 32'(busy_o[c]), 32'(eb));
        chk("done", 32'(done_o[c]), 32'(ed));
        chk("calc_valid", 32'(cv_o[c]), 32'(ev));
        if (ev) begin
          if (c == 0) lexp = ext_l; else lexp = old_g[c-1][r];
          if (c == NC - 1) rexp = ext_r; else rexp = old_g[c+1][r];
          chk("calc_row", 32'(crow_o[c]), 32'(r));
          chk("node_center", nc_o[c], old_g[c][r]);
          chk("center_out", ctr_o[c], old_g[c][r]);
          chk("node_up", up_o[c], old_g[c][r-1]);
          chk("node_down", dn_o[c], old_g[c][r+1]);
          chk("node_left", nl_o[c], lexp);
          chk("node_right", nr_o[c], rexp);
        end
        if (eb) chk("disp_hold", dd_o[c], hold_exp[c]);
      end
      if (cv_o[0]) begin
        cv_cnt++;
        if (cv_first < 0) cv_first = int'(crow_o[0]);
        cv_last = int'(crow_o[0]);
      end
      if (done_o[0]) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all();
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        we_v[c] = 1'b1;
        wa_v[c] = 8'(r);
        wd_v[c] = cur[c][r];
      end
      tick();
    end
    for (int c = 0; c < NC; c++) we_v[c] = 1'b0;
  endtask

  task automatic readback_all();
    for (int r = 0; r <= NR; r++) begin
      if (r < NR) disp_a = 8'(r);
      @(negedge clk);
      if (r > 0)
        for (int c = 0; c < NC; c++) chk("readback", dd_o[c], cur[c][r-1]);
      tick();
    end
  endtask

  task automatic disp_check(input int c, input int r, input logic [31:0] exp_v, input string name);
    disp_a = 8'(r);
    tick();
    @(negedge clk);
    chk(name, dd_o[c], exp_v);
    tick();
  endtask

  task automatic run_step(input bit mid_junk, input int rst_at, input bit same_wr);
    int wr;
    logic [31:0] wdat;
    wr     = $urandom_range(1, NR - 2);
    wdat   = rand_fp();
    disp_a = 8'((wr + 7) % NR);
    for (int c = 0; c < NC; c++) hold_exp[c] = cur[c][disp_a];
    if (same_wr)
      for (int c = 0; c < NC; c++) begin
        we_v[c] = 1'b1;
        wa_v[c] = 8'(wr);
        wd_v[c] = wdat + 32'(c);
        cur[c][wr] = wdat + 32'(c);
      end
    model_step();
    s_cyc    = cyc;
    cv_cnt   = 0;
    cv_first = -1;
    cv_last  = -1;
    done_cnt = 0;
    done_cyc = -1;
    step_on  = 1'b1;
    start_v  = 1'b1;
    tick();
    start_v = 1'b0;
    for (int c = 0; c < NC; c++) we_v[c] = 1'b0;
    while (cyc < s_cyc + NR + 3) begin
      start_v = mid_junk && (cyc == s_cyc + 50);
      for (int c = 0; c < NC; c++) begin
        we_v[c] = mid_junk && (cyc == s_cyc + 60);
        wa_v[c] = 8'($urandom_range(0, NR - 1));
        wd_v[c] = rand_fp();
      end
      if (mid_junk && cyc == s_cyc + 30) disp_a = 8'($urandom_range(0, NR - 1));
      if (cyc == s_cyc + rst_at) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        step_on = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy_o[1]), 32'd0);
        chk("reset_calc_valid", 32'(cv_o[1]), 32'd0);
        tick();
        return;
      end
      tick();
    end
    start_v = 1'b0;
    for (int c = 0; c < NC; c++) we_v[c] = 1'b0;
    step_on = 1'b0;
    cur = exp_g;
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("done_cycle", 32'(done_cyc), 32'(s_cyc + 258));
  endtask

  task automatic fill_impulse();
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) cur[c][r] = '0;
    cur[1][5]  = FP_ONE;
    cur[1][10] = FP_ONE;
    alpha = ALPHA_Q;
    ext_l = '0;
    ext_r = '0;
  endtask

  task automatic check_impulse(input string tag);
    chk({tag, "_model_r4"}, cur[1][4], 32'h0200_0000);
    chk({tag, "_model_r5"}, cur[1][5], 32'h0000_0000);
    disp_check(1, 4, 32'h0200_0000, {tag, "_row4"});
    disp_check(1, 6, 32'h0200_0000, {tag, "_row6"});
    disp_check(1, 5, 32'h0000_0000, {tag, "_row5"});
    disp_check(0, 10, 32'h0200_0000, {tag, "_left_row10"});
    disp_check(2, 10, 32'h0200_0000, {tag, "_right_row10"});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    start_v = 1'b0;
    disp_a  = '0;
    ext_l   = '0;
    ext_r   = '0;
    alpha   = ALPHA_Q;
    for (int c = 0; c < NC; c++) begin
      we_v[c] = 1'b0;
      wa_v[c] = '0;
      wd_v[c] = '0;
    end
    reset_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      chk("rst_busy", 32'(busy_o[c]), 32'd0);
      chk("rst_done", 32'(done_o[c]), 32'd0);
      chk("rst_calc_valid", 32'(cv_o[c]), 32'd0);
      chk("rst_calc_row", 32'(crow_o[c]), 32'd0);
      chk("rst_center_out", ctr_o[c], 32'd0);
    end
    tick();
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick();

    // Unit impulse in the middle column.
    fill_impulse();
    load_all();
    run_step(1'b0, -1, 1'b0);
    check_impulse("impulse");
    readback_all();

    // Vertical ramp: boundary rows fixed, calc_row walks 1..254.
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) cur[c][r] = 32'(r) << 20;
    load_all();
    run_step(1'b0, -1, 1'b0);
    chk("ramp_calc_count", 32'(cv_cnt), 32'd254);
    chk("ramp_first_row", 32'(cv_first), 32'd1);
    chk("ramp_last_row", 32'(cv_last), 32'd254);
    disp_check(0, 0, 32'h0000_0000, "ramp_row0");
    disp_check(0, 255, 32'h0FF0_0000, "ramp_row255");
    readback_all();

    // Restart and load attempts while busy, strong source/sink at the edges.
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) cur[c][r] = rand_fp();
    ext_l = FP_SRC;
    ext_r = FP_SNK;
    load_all();
    run_step(1'b1, -1, 1'b1);
    readback_all();

    // Reset mid-step, then reload the impulse and repeat it.
    ext_l = '0;
    ext_r = '0;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) cur[c][r] = rand_fp();
    load_all();
    run_step(1'b0, 100, 1'b0);
    fill_impulse();
    load_all();
    run_step(1'b0, -1, 1'b0);
    check_impulse("post_reset");
    readback_all();

    // Back-to-back random steps carrying state forward.
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) cur[c][r] = rand_fp();
    load_all();
    for (int k = 0; k < 3; k++) begin
      alpha = 32'($urandom_range(0, 32'h0200_0000));
      ext_l = rand_fp();
      ext_r = rand_fp();
      repeat ($urandom_range(0, 3)) tick();
      run_step(1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)));
      readback_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
